ctr_ciphertext_serializer: RTL and testbench
============================================

Name: ctr_ciphertext_serializer

Overview:
- Downstream stage of the AES-256 CTR encryptor.
- Takes each wide ciphertext block (default 1024 b) produced by the CTR stage and streams it out as WORD_W-bit words over a valid/ready interface to the bus/output logic.
- Two-deep buffering: one active shift register and one pending register. The CTR stage can hand over the next block while the current one is still draining.

Parameters:
- BLOCK_W, 1024: width of the incoming ciphertext block. Must equal the CTR stage PLAINTEXTIN and be a multiple of 128.
- WORD_W, 32: output word width. BLOCK_W % WORD_W == 0 is required; a simulation-time check fatals otherwise.
- NWORDS (localparam), BLOCK_W/WORD_W: words per block (32 at defaults).
- CNT_W (localparam), $clog2(NWORDS): word index width.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset. rst==0 at a posedge resets the block.
- block_i  in  BLOCK_W  ciphertext block from the CTR stage; word 0 is block_i[WORD_W-1:0].
- block_valid_i  in  1  block_i is valid this cycle.
- block_ready_o  out  1  serializer can accept a block this cycle.
- word_o  out  WORD_W  current output word.
- word_valid_o  out  1  word_o is valid.
- word_ready_i  in  1  consumer accepts word_o this cycle.
- word_last_o  out  1  word_o is the final word (index NWORDS-1) of its block.
- word_idx_o  out  CNT_W  index of word_o within its block.
- busy_o  out  1  state != IDLE or pending buffer full.

Behaviour:
- Handshakes:
  - Block accept = block_valid_i & block_ready_o.
  - Word transfer = word_valid_o & word_ready_i.
  - Both take effect at the posedge.
- State machine: IDLE, SEND.
- Reset (rst==0 at posedge): state=IDLE, active/pending regs=0, pend_full=0, count=0.
  - Outputs: word_valid_o=0, word_o=0, word_last_o=0, word_idx_o=0, busy_o=0.
  - block_ready_o is forced 0 while rst==0.
  - Reset mid-block discards all buffered data. No partial word or last is emitted afterwards.
- block_ready_o = ~pend_full (when rst==1). It is purely state-based, with no combinational path from word_ready_i.
- IDLE:
  - word_valid_o=0.
  - On block accept: active<=block_i, count<=0, go to SEND.
  - Latency: first word is valid the cycle after accept.
- SEND:
  - word_valid_o=1, word_o=active[WORD_W-1:0], word_idx_o=count, word_last_o=(count==NWORDS-1).
  - word_o must hold stable while word_ready_i==0.
  - Non-last transfer: active<=active>>WORD_W, count<=count+1.
  - Block accept with no last transfer: pending<=block_i, pend_full<=1.
  - Last-word transfer:
    - If pend_full: active<=pending, pend_full<=0, count<=0, stay in SEND. Any block accept this cycle is impossible, because ready is 0.
    - Else, if block accept the same cycle: active<=block_i, count<=0, stay in SEND. This gives zero bubble.
    - Else: go to IDLE, count<=0.
- Throughput: with word_ready_i held 1 and blocks supplied early enough, one word per cycle with no gaps between blocks.
- Ordering: blocks leave in arrival order. Within a block, words leave LSB-first, matching the CTR stage's 128-bit segment order (segment k = bits k*128+127:k*128).
- Blocks can never be dropped: a block presented while pend_full=1 is simply not accepted (ready=0).
- block_valid_i with block_ready_o==0 has no effect.

Decomposition:
- Shared package ctr_pkg holds:
  - state encoding constants ST_IDLE / ST_SEND;
  - default widths CTR_BLOCK_W=1024, CTR_WORD_W=32, shared with the CTR encryptor's PLAINTEXTIN.
- No sub-module required. The pending-register + valid bit may optionally be a small ctr_block_skid sub-module (BLOCK_W-wide register with full flag, load/unload).

Test Plan:
- Reset: hold rst=0 for 3 cycles with block_valid_i=1 -> block_ready_o=0, word_valid_o=0, word_o=0. After rst=1: block_ready_o=1, busy_o=0.
- Single block: block_i = word k equal to 32'h1000_0000+k, one-cycle valid, word_ready_i=1.
  - Words appear on cycles 1..32 after accept with values 0x10000000..0x1000001F.
  - word_idx_o 0..31; word_last_o only on the 32nd word.
  - Returns to IDLE (busy_o=0) the next cycle.
- Backpressure: toggle word_ready_i 1,0,0,1 repeatedly -> word_o and word_idx_o stable during stalls. Exactly 32 transfers, none duplicated or skipped.
- Back-to-back blocks: present block B (all words 0xBBBB0000+k) while block A is on word 5 -> B goes to pending, block_ready_o=0. Block C is then held off until A's last word. First word of B follows A's last word with no gap. C is accepted the cycle B becomes active.
- Simultaneous last + accept with empty pending: offer block D exactly on A's last-word transfer -> D accepted. D word 0 is valid the next cycle with no IDLE cycle.
- Reset mid-operation: rst=0 during word 17 of a block with pending full -> all outputs return to reset values. After release, a new block streams from word 0 with no residual data from either buffer.

Source files
------------

// File: rtl/ctr_pkg.sv
// rtl/ctr_pkg.sv - shared CTR datapath widths and serializer state encoding
package ctr_pkg;

    localparam int CTR_BLOCK_W = 1024;
    localparam int CTR_WORD_W  = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ctr_state_e;

endpackage

// File: rtl/ctr_block_skid.sv
// rtl/ctr_block_skid.sv - single-entry block holding register with full flag
module ctr_block_skid #(
    parameter int W = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    // load is only issued while empty and unload only while full,
    // so the two never collide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout <= '0;
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ctr_ciphertext_serializer.sv
// rtl/ctr_ciphertext_serializer.sv - streams wide ciphertext blocks out as LSB-first words
module ctr_ciphertext_serializer
    import ctr_pkg::*;
#(
    parameter int BLOCK_W = CTR_BLOCK_W,
    parameter int WORD_W  = CTR_WORD_W,
    localparam int NWORDS = BLOCK_W / WORD_W,
    localparam int CNT_W  = $clog2(NWORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] block_i,
    input  logic               block_valid_i,
    output logic               block_ready_o,
    output logic [WORD_W-1:0]  word_o,
    output logic               word_valid_o,
    input  logic               word_ready_i,
    output logic               word_last_o,
    output logic [CNT_W-1:0]   word_idx_o,
    output logic               busy_o
);

    if ((BLOCK_W % WORD_W) != 0 || (BLOCK_W % 128) != 0) begin : g_param_check
        $fatal(1, "ctr_ciphertext_serializer: BLOCK_W must be a multiple of 128 and of WORD_W");
    end

    ctr_state_e          state_q, state_d;
    logic [BLOCK_W-1:0]  active_q, active_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [BLOCK_W-1:0]  pend_data;
    logic                pend_full;
    logic                pend_load;
    logic                pend_unload;

    logic                sending;
    logic                is_last;
    logic                word_fire;
    logic                block_fire;
    logic                last_fire;

    assign sending    = (state_q == ST_SEND);
    assign is_last    = (count_q == CNT_W'(NWORDS - 1));
    assign word_fire  = sending & word_ready_i;
    assign last_fire  = word_fire & is_last;

    // Ready depends only on registered state (and reset), never on word_ready_i.
    assign block_ready_o = rst & ~pend_full;
    assign block_fire    = block_valid_i & block_ready_o;

    // A block arriving during SEND parks in the pending slot, unless it lands
    // exactly on the last-word transfer with the slot empty: then it goes
    // straight into the active register for a zero-bubble handover.
    assign pend_load   = block_fire & sending & ~last_fire;
    assign pend_unload = last_fire & pend_full;

    ctr_block_skid #(
        .W (BLOCK_W)
    ) u_pending (
        .clk    (clk),
        .rst    (rst),
        .load   (pend_load),
        .unload (pend_unload),
        .din    (block_i),
        .dout   (pend_data),
        .full   (pend_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            active_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        count_d  = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (block_fire) begin
                    active_d = block_i;
                    count_d  = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (word_fire) begin
                    if (!is_last) begin
                        active_d = active_q >> WORD_W;
                        count_d  = count_q + CNT_W'(1);
                    end else if (pend_full) begin
                        active_d = pend_data;
                        count_d  = '0;
                    end else if (block_fire) begin
                        active_d = block_i;
                        count_d  = '0;
                    end else begin
                        count_d  = '0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Word outputs are gated by SEND so IDLE never shows leftover shifted data.
    assign word_valid_o = sending;
    assign word_o       = sending ? active_q[WORD_W-1:0] : '0;
    assign word_idx_o   = count_q;
    assign word_last_o  = sending & is_last;
    assign busy_o       = sending | pend_full;

endmodule

// File: tb/tb_ctr_ciphertext_serializer.sv
// tb/tb_ctr_ciphertext_serializer.sv - directed self-checking bench for ctr_ciphertext_serializer
module tb_ctr_ciphertext_serializer;

    localparam int BW = 1024;
    localparam int WW = 32;
    localparam int NW = BW / WW;

    logic          clk;
    logic          rst;
    logic [BW-1:0] block_i;
    logic          block_valid_i;
    logic          block_ready_o;
    logic [WW-1:0] word_o;
    logic          word_valid_o;
    logic          word_ready_i;
    logic          word_last_o;
    logic [4:0]    word_idx_o;
    logic          busy_o;

    int nvec;
    int nerr;

    ctr_ciphertext_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .block_i       (block_i),
        .block_valid_i (block_valid_i),
        .block_ready_o (block_ready_o),
        .word_o        (word_o),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .word_last_o   (word_last_o),
        .word_idx_o    (word_idx_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk_block(input logic [31:0] base);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < NW; k++) b[k*WW +: WW] = base + 32'(k);
        return b;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [31:0] base, input int k);
        chk({tag, "_valid"}, 64'(word_valid_o), 64'd1);
        chk({tag, "_word"},  64'(word_o),       64'(base + 32'(k)));
        chk({tag, "_idx"},   64'(word_idx_o),   64'(k));
        chk({tag, "_last"},  64'(word_last_o),  64'(k == NW - 1));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_valid"}, 64'(word_valid_o), 64'd0);
        chk({tag, "_busy"},  64'(busy_o),       64'd0);
    endtask

    initial begin
        int k;
        int cyc;
        int xfers;
        nvec = 0;
        nerr = 0;

        // Reset held with a block offered: nothing accepted, outputs quiet.
        rst           = 1'b0;
        block_valid_i = 1'b1;
        block_i       = mk_block(32'h1000_0000);
        word_ready_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 64'(block_ready_o), 64'd0);
            chk("rst_valid", 64'(word_valid_o),  64'd0);
            chk("rst_word",  64'(word_o),        64'd0);
            chk("rst_last",  64'(word_last_o),   64'd0);
            chk("rst_idx",   64'(word_idx_o),    64'd0);
            chk("rst_busy",  64'(busy_o),        64'd0);
        end
        rst           = 1'b1;
        block_valid_i = 1'b0;
        #1;
        chk("post_rst_ready", 64'(block_ready_o), 64'd1);
        chk("post_rst_busy",  64'(busy_o),        64'd0);

        // Single block, consumer always ready.
        block_i       = mk_block(32'h1000_0000);
        block_valid_i = 1'b1;
        tick();
        block_valid_i = 1'b0;
        for (k = 0; k < NW; k++) begin
            expect_word("single", 32'h1000_0000, k);
            tick();
        end
        expect_idle("single_end");

        // Backpressure pattern 1,0,0,1: words hold during stalls.
        block_i       = mk_block(32'h2000_0000);
        block_valid_i = 1'b1;
        tick();
        block_valid_i = 1'b0;
        xfers = 0;
        cyc   = 0;
        while (xfers < NW && cyc < 400) begin
            word_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            expect_word("bp", 32'h2000_0000, xfers);
            tick();
            if (word_ready_i) xfers++;
            cyc++;
        end
        chk("bp_xfers", 64'(xfers), 64'(NW));
        word_ready_i = 1'b1;
        expect_idle("bp_end");

        // Back-to-back: B pends during A, C held off until B becomes active.
        block_i       = mk_block(32'hAAAA_0000);
        block_valid_i = 1'b1;
        tick();
        block_valid_i = 1'b0;
        for (k = 0; k < NW; k++) begin
            expect_word("b2b_a", 32'hAAAA_0000, k);
            if (k == 5) begin
                block_i       = mk_block(32'hBBBB_0000);
                block_valid_i = 1'b1;
                chk("b2b_ready_b", 64'(block_ready_o), 64'd1);
            end else if (k == 6) begin
                chk("b2b_ready_held", 64'(block_ready_o), 64'd0);
                chk("b2b_busy",       64'(busy_o),        64'd1);
                block_i = mk_block(32'hCCCC_0000);
            end else if (k > 6) begin
                chk("b2b_ready_held", 64'(block_ready_o), 64'd0);
            end
            tick();
        end
        expect_word("b2b_b", 32'hBBBB_0000, 0);
        chk("b2b_ready_c", 64'(block_ready_o), 64'd1);
        tick();
        block_valid_i = 1'b0;
        chk("b2b_c_pend", 64'(block_ready_o), 64'd0);
        for (k = 1; k < NW; k++) begin
            expect_word("b2b_b", 32'hBBBB_0000, k);
            tick();
        end
        for (k = 0; k < NW; k++) begin
            expect_word("b2b_c", 32'hCCCC_0000, k);
            tick();
        end
        expect_idle("b2b_end");

        // Block offered exactly on the last-word transfer with pending empty.
        block_i       = mk_block(32'h5A5A_0000);
        block_valid_i = 1'b1;
        tick();
        block_valid_i = 1'b0;
        for (k = 0; k < NW; k++) begin
            expect_word("zb_a", 32'h5A5A_0000, k);
            if (k == NW - 1) begin
                block_i       = mk_block(32'hDDDD_0000);
                block_valid_i = 1'b1;
                chk("zb_ready", 64'(block_ready_o), 64'd1);
            end
            tick();
        end
        block_valid_i = 1'b0;
        chk("zb_ready_after", 64'(block_ready_o), 64'd1);
        for (k = 0; k < NW; k++) begin
            expect_word("zb_d", 32'hDDDD_0000, k);
            tick();
        end
        expect_idle("zb_end");

        // Reset mid-block with pending full discards both buffers.
        block_i       = mk_block(32'hF0F0_0000);
        block_valid_i = 1'b1;
        tick();
        block_valid_i = 1'b0;
        for (k = 0; k < 18; k++) begin
            expect_word("mr_f", 32'hF0F0_0000, k);
            if (k == 2) begin
                block_i       = mk_block(32'h6060_0000);
                block_valid_i = 1'b1;
            end else begin
                block_valid_i = 1'b0;
            end
            if (k == 17) begin
                chk("mr_pend_full", 64'(block_ready_o), 64'd0);
                rst = 1'b0;
            end
            if (k < 17) tick();
        end
        tick();
        chk("mr_valid", 64'(word_valid_o),  64'd0);
        chk("mr_word",  64'(word_o),        64'd0);
        chk("mr_last",  64'(word_last_o),   64'd0);
        chk("mr_idx",   64'(word_idx_o),    64'd0);
        chk("mr_busy",  64'(busy_o),        64'd0);
        chk("mr_ready", 64'(block_ready_o), 64'd0);
        rst = 1'b1;
        #1;
        chk("mr_ready_rel", 64'(block_ready_o), 64'd1);
        tick();
        expect_idle("mr_idle");
        block_i       = mk_block(32'h7777_0000);
        block_valid_i = 1'b1;
        tick();
        block_valid_i = 1'b0;
        for (k = 0; k < NW; k++) begin
            expect_word("mr_h", 32'h7777_0000, k);
            tick();
        end
        expect_idle("mr_end");
        tick();
        expect_idle("mr_end2");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
